// File: rtl/count_run_ctrl.sv
// count_run_ctrl: run controller for the lab counter datapath.
// A run is started with a target value and a direction. The counter then steps
// by one every HOLD_CYCLES clocks until it reaches the target. A run can be
// paused, resumed or aborted.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   start   - run request, sampled only in IDLE
//   dir     - step direction latched on start (1 = up, 0 = down)
//   target  - end value latched on start
//   pause   - level, holds the run while high
//   abort   - level, cancels the run
//   count   - current counter value (registered)
//   busy    - high in RUN and PAUSE (registered)
//   done    - one-cycle pulse when a run completes (registered)
//   wrap    - one-cycle pulse on a modulo step (registered)
module count_run_ctrl #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] target,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam int unsigned PW = 8;
    localparam logic [PW-1:0]    PRE_LAST = PW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state,     state_n;
    logic [PW-1:0]    prescaler, prescaler_n;
    logic             dir_q,     dir_n;
    logic [WIDTH-1:0] target_q,  target_n;
    logic [WIDTH-1:0] count_n;
    logic             busy_n, done_n, wrap_n;

    logic             advance_c;
    logic [WIDTH-1:0] step_val_c;
    logic             step_wrap_c;

    // Next counter value and boundary crossing for the latched direction.
    always_comb begin
        step_val_c  = dir_q ? WIDTH'(count + WIDTH'(1)) : WIDTH'(count - WIDTH'(1));
        step_wrap_c = dir_q ? (count == CNT_MAX) : (count == '0);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= '0;
            prescaler <= '0;
            dir_q     <= 1'b1;
            target_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            prescaler <= prescaler_n;
            dir_q     <= dir_n;
            target_q  <= target_n;
            busy      <= busy_n;
            done      <= done_n;
            wrap      <= wrap_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        count_n     = count;
        prescaler_n = prescaler;
        dir_n       = dir_q;
        target_n    = target_q;
        busy_n      = busy;
        done_n      = 1'b0;
        wrap_n      = 1'b0;
        advance_c   = 1'b0;

        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    dir_n       = dir;
                    target_n    = target;
                    prescaler_n = '0;
                    if (target == count) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_RUN;
                        busy_n  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else if (pause) begin
                    state_n = S_PAUSE;
                end else begin
                    advance_c = 1'b1;
                end
            end
            S_PAUSE: begin
                // The resume edge does the work of a normal RUN edge, so a
                // pause costs exactly the number of clocks pause was high.
                if (abort) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end else if (!pause) begin
                    state_n   = S_RUN;
                    advance_c = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
            end
        endcase

        // Prescaler tick / counter step.
        if (advance_c) begin
            if (prescaler == PRE_LAST) begin
                prescaler_n = '0;
                count_n     = step_val_c;
                wrap_n      = step_wrap_c;
                if (step_val_c == target_q) begin
                    state_n = S_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end else begin
                prescaler_n = PW'(prescaler + PW'(1));
            end
        end
    end

endmodule
